// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage of the RV32I core. It accepts one decoded load or
//   store, forms the effective address and drives a word-organised data
//   memory through a req/ack handshake. An access that crosses a word
//   boundary is issued as two word transactions. Illegal or out-of-range
//   accesses complete immediately with fault=1 and never touch memory.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   start / ready            request handshake (ready high only in IDLE)
//   is_load, is_store        access type, sampled at accept
//   funct3                   size/sign, sampled at accept
//   rs1_value, imm           base + offset, sampled at accept
//   rs2_value                store data, sampled at accept
//   mem_req, mem_we          memory request / write enable
//   mem_addr, mem_be         word address and byte-lane enables
//   mem_wdata                lane-positioned write data
//   mem_rdata, mem_ack       read data and transaction-complete strobe
//   done, fault, rd_data     completion pulse, illegal flag, load result
module load_store_unit #(
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_value,
  input  logic [31:0] imm,
  input  logic [31:0] rs2_value,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        done,
  output logic        fault,
  output logic [31:0] rd_data
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t      state_q;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        split_q;
  logic [3:0]  be1_q;
  logic [31:0] wdata1_q;
  logic [31:0] word0_q;
  logic        mem_req_q, mem_we_q;
  logic [29:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic        done_q, fault_q;
  logic [31:0] rd_data_q;

  // Accept-time decode of the incoming request
  logic [31:0] addr_d;
  logic [2:0]  size_d;
  logic [3:0]  bmask_d;
  logic        legal_d;
  logic [32:0] last_byte_d;
  logic        fault_d;
  logic [7:0]  lanes_d;
  logic [31:0] sdata_d;
  logic [63:0] sh_d;
  logic        split_d;

  // Completion-time load assembly
  logic [63:0] win_d;
  logic [31:0] ld_raw_d;
  logic [31:0] rd_data_d;

  // Sign/zero extension of the gathered little-endian bytes.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [2:0]  f3);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{raw[7]}}, raw[7:0]};
      3'b001:  r = {{16{raw[15]}}, raw[15:0]};
      3'b100:  r = {24'b0, raw[7:0]};
      3'b101:  r = {16'b0, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  always_comb begin
    addr_d  = rs1_value + imm;
    size_d  = 3'd4;
    bmask_d = 4'b1111;
    case (funct3[1:0])
      2'b00: begin size_d = 3'd1; bmask_d = 4'b0001; end
      2'b01: begin size_d = 3'd2; bmask_d = 4'b0011; end
      default: ;
    endcase

    legal_d = 1'b0;
    if (is_load && !is_store)
      legal_d = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    else if (is_store && !is_load)
      legal_d = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);

    // One extra bit so an address near 2^32 cannot wrap into range.
    last_byte_d = {1'b0, addr_d} + 33'(size_d) - 33'd1;
    fault_d     = !legal_d || (last_byte_d >= 33'(DMEM_BYTES));

    // Lanes and data over an 8-byte window: low half is word 0, high half word 1.
    lanes_d = {4'b0, bmask_d} << addr_d[1:0];
    sdata_d = is_store ? (rs2_value & {{8{bmask_d[3]}}, {8{bmask_d[2]}},
                                       {8{bmask_d[1]}}, {8{bmask_d[0]}}}) : 32'b0;
    sh_d    = {32'b0, sdata_d} << {addr_d[1:0], 3'b000};
    split_d = |lanes_d[7:4];

    // In ACC1 the held word 0 supplies the low bytes of the window.
    win_d     = (state_q == ACC1) ? {mem_rdata, word0_q} : {32'b0, mem_rdata};
    ld_raw_d  = 32'(win_d >> {off_q, 3'b000});
    rd_data_d = is_load_q ? extend_load(ld_raw_d, funct3_q) : 32'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'b0;
      off_q       <= 2'b0;
      split_q     <= 1'b0;
      be1_q       <= 4'b0;
      wdata1_q    <= 32'b0;
      word0_q     <= 32'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 30'b0;
      mem_be_q    <= 4'b0;
      mem_wdata_q <= 32'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rd_data_q   <= 32'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_load_q <= is_load;
            funct3_q  <= funct3;
            off_q     <= addr_d[1:0];
            split_q   <= split_d;
            be1_q     <= lanes_d[7:4];
            wdata1_q  <= sh_d[63:32];
            if (fault_d) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              fault_q   <= 1'b1;
              rd_data_q <= 32'b0;
            end else begin
              state_q     <= ACC0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= addr_d[31:2];
              mem_be_q    <= lanes_d[3:0];
              mem_wdata_q <= sh_d[31:0];
            end
          end
        end
        ACC0, ACC1: begin
          if (mem_ack) begin
            if (state_q == ACC0 && split_q) begin
              // Hand straight over to word 1; mem_req stays high.
              state_q     <= ACC1;
              word0_q     <= mem_rdata;
              mem_addr_q  <= mem_addr_q + 30'd1;
              mem_be_q    <= be1_q;
              mem_wdata_q <= wdata1_q;
            end else begin
              state_q     <= DONE;
              mem_req_q   <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= 30'b0;
              mem_be_q    <= 4'b0;
              mem_wdata_q <= 32'b0;
              done_q      <= 1'b1;
              fault_q     <= 1'b0;
              rd_data_q   <= rd_data_d;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit. Inputs are driven and outputs
//   sampled on the falling clock edge; the bench plays the memory by hand,
//   supplying mem_rdata/mem_ack cycle by cycle.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, ready;
  logic        is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] rs1_value, imm, rs2_value;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        done, fault;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.DMEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .rs1_value(rs1_value), .imm(imm), .rs2_value(rs2_value),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .done(done), .fault(fault), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at cycle 1 after accept.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] base, input logic [31:0] ofs,
                       input logic [31:0] data);
    is_load = ld; is_store = st; funct3 = f3;
    rs1_value = base; imm = ofs; rs2_value = data; start = 1'b1;
    chk("ready_before_accept", ready, 1);
    @(negedge clk);
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    chk("ready_after_accept", ready, 0);
  endtask

  task automatic expect_req(input string tag, input logic we,
                            input logic [29:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_we"}, mem_we, we);
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_be"}, mem_be, be);
    if (we) chk({tag, "_wdata"}, mem_wdata, wdata);
    chk({tag, "_nodone"}, done, 0);
  endtask

  // Ack the current request with rdata in zero wait states.
  task automatic ack(input logic [31:0] rdata);
    mem_rdata = rdata; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  // Called in the DONE cycle.
  task automatic expect_done(input string tag, input logic f, input logic [31:0] rd);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_fault"}, fault, f);
    chk({tag, "_rd"}, rd_data, rd);
    chk({tag, "_req_low"}, mem_req, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_rd_hold"}, rd_data, rd);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b0;
    rs1_value = 32'h0; imm = 32'h0; rs2_value = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rd", rd_data, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Aligned SW, A = 0x20 + (-0x10) = 0x10
    issue(1'b0, 1'b1, 3'b010, 32'h20, 32'hFFFF_FFF0, 32'hDEADBEEF);
    expect_req("sw", 1'b1, 30'h4, 4'b1111, 32'hDEADBEEF);
    ack(32'h0);
    expect_done("sw", 1'b0, 32'h0);

    // Sign handling on word 0x20 = 0x8081F0FF
    issue(1'b1, 1'b0, 3'b000, 32'h22, 32'h0, 32'h0);
    expect_req("lb", 1'b0, 30'h8, 4'b0100, 32'h0);
    ack(32'h8081F0FF);
    expect_done("lb", 1'b0, 32'hFFFFFF81);

    issue(1'b1, 1'b0, 3'b100, 32'h22, 32'h0, 32'h0);
    expect_req("lbu", 1'b0, 30'h8, 4'b0100, 32'h0);
    ack(32'h8081F0FF);
    expect_done("lbu", 1'b0, 32'h00000081);

    issue(1'b1, 1'b0, 3'b001, 32'h20, 32'h0, 32'h0);
    expect_req("lh", 1'b0, 30'h8, 4'b0011, 32'h0);
    ack(32'h8081F0FF);
    expect_done("lh", 1'b0, 32'hFFFFF0FF);

    issue(1'b1, 1'b0, 3'b101, 32'h20, 32'h0, 32'h0);
    expect_req("lhu", 1'b0, 30'h8, 4'b0011, 32'h0);
    ack(32'h8081F0FF);
    expect_done("lhu", 1'b0, 32'h0000F0FF);

    // Split SH at A = 0x0B
    issue(1'b0, 1'b1, 3'b001, 32'h0B, 32'h0, 32'h0000ABCD);
    expect_req("sh_w0", 1'b1, 30'h2, 4'b1000, 32'hCD000000);
    ack(32'h0);
    expect_req("sh_w1", 1'b1, 30'h3, 4'b0001, 32'h000000AB);
    ack(32'h0);
    expect_done("sh", 1'b0, 32'h0);

    // Split LW at A = 0x40 + 3 = 0x43
    issue(1'b1, 1'b0, 3'b010, 32'h40, 32'h3, 32'h0);
    expect_req("lw_split_w0", 1'b0, 30'h10, 4'b1000, 32'h0);
    ack(32'h44332211);
    expect_req("lw_split_w1", 1'b0, 30'h11, 4'b0111, 32'h0);
    ack(32'h88776655);
    expect_done("lw_split", 1'b0, 32'h77665544);

    // Faults: done at cycle 1, no request, rd_data cleared
    issue(1'b1, 1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0);
    chk("f_range_req", mem_req, 0);
    expect_done("f_range", 1'b1, 32'h0);

    // Last legal word is accepted
    issue(1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0);
    expect_req("lw_top", 1'b0, 30'h0FF, 4'b1111, 32'h0);
    ack(32'hCAFEF00D);
    expect_done("lw_top", 1'b0, 32'hCAFEF00D);

    issue(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0);
    chk("f_f3_req", mem_req, 0);
    expect_done("f_f3", 1'b1, 32'h0);

    issue(1'b1, 1'b1, 3'b010, 32'h0, 32'h0, 32'h0);
    chk("f_both_req", mem_req, 0);
    expect_done("f_both", 1'b1, 32'h0);

    // Stray ack while idle is ignored
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_done", done, 0);
    chk("stray_ack_ready", ready, 1);

    // Aligned LW with three wait cycles: ack in cycle 4, done in cycle 5
    issue(1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      expect_req("lw_wait", 1'b0, 30'h14, 4'b1111, 32'h0);
      @(negedge clk);
    end
    expect_req("lw_wait_ack", 1'b0, 30'h14, 4'b1111, 32'h0);
    ack(32'h12345678);
    expect_done("lw_wait", 1'b0, 32'h12345678);

    // Reset pulled low during ACC1 of a split load
    issue(1'b1, 1'b0, 3'b010, 32'h43, 32'h0, 32'h0);
    ack(32'h44332211);
    expect_req("rst_mid_w1", 1'b0, 30'h11, 4'b0111, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_done2", done, 0);
    @(negedge clk);
    chk("rst_mid_done3", done, 0);
    chk("rst_mid_ready2", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV32I core. It consumes a decoded load or store (base register, immediate, store data, funct3) from the execute stage. It drives a 32-bit word-organised data memory through a req/ack handshake and returns aligned, extended load data for register write-back. Misaligned accesses that cross a word boundary are split into two word transactions; out-of-range and illegal accesses are flagged without touching memory.

## Interface
- DMEM_BYTES, 1024: data memory size in bytes; legal byte addresses are 0..DMEM_BYTES-1; multiple of 4, at most 2^31.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request valid; accepted only when ready=1.
- ready  out  1  high only in IDLE.
- is_load  in  1  load opcode, sampled at accept.
- is_store  in  1  store opcode, sampled at accept.
- funct3  in  3  access size and sign, sampled at accept.
- rs1_value  in  32  base address, sampled at accept.
- imm  in  32  sign-extended offset, sampled at accept.
- rs2_value  in  32  store data, sampled at accept.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  30  word address (byte address >> 2).
- mem_be  out  4  byte-lane enables; lane i is bits 8i+7:8i.
- mem_wdata  out  32  write data, lane-positioned.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  transaction complete.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; access was illegal.
- rd_data  out  32  load result, valid with done.

## Operation
- Effective address: A = rs1_value + imm, modulo 2^32. Size n comes from funct3[1:0]: 00→1, 01→2, 10→4. Offset off = A[1:0].
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
- The access faults when any of these holds:
  - is_load and is_store are both 0 or both 1;
  - funct3 is illegal for the access type;
  - A+n-1 ≥ DMEM_BYTES, computed without 32-bit overflow.
- A faulting access goes straight to DONE with fault=1 and rd_data=0. No mem_req is issued.
- Split: the access needs two transactions when off+n > 4.
  - Word 0: address A>>2, lanes off..min(3, off+n-1).
  - Word 1: address (A>>2)+1, lanes 0..off+n-5.
- Store data: bytes s0..s(n-1) of rs2_value, little-endian. Byte k goes to byte address A+k, placed in its lane. Disabled lanes of mem_wdata are 0.
- Load assembly:
  - Bytes are gathered into a little-endian n-byte value.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - Word 0 bytes are captured on its ack and held internally.
- Stores complete with rd_data=0.
- States:
  - IDLE: start → ACC0, or DONE on fault.
  - ACC0: mem_ack → ACC1 if split, else DONE.
  - ACC1: mem_ack → DONE.
  - DONE: always → IDLE.

## Timing
- Reset values:
  - state = IDLE, so ready=1;
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata = 0;
  - done, fault, rd_data = 0.
- Reset asserted mid-transaction returns to IDLE immediately. mem_req drops asynchronously and no done is produced.
- mem_req=1 throughout ACC0 and ACC1. All memory outputs are registered and stable while mem_req=1.
- A transaction completes in the first cycle where mem_req=1 and mem_ack=1; zero-wait ack is allowed. mem_ack outside ACC0/ACC1 is ignored.
- ACC1 presents word 1 in the cycle after the ACC0 ack. mem_req stays high across the boundary.
- done pulses for exactly one cycle, in DONE. rd_data and fault hold their values until the next done.
- ready=0 from the cycle after accept through DONE. A new start is accepted in the cycle after DONE.
- Latency, start accepted at cycle 0, zero-wait memory:
  - aligned access: req at cycle 1, done at cycle 2;
  - split access: reqs at cycles 1–2, done at cycle 3;
  - fault: done at cycle 1.
- Each wait cycle adds one cycle of latency.

## Test plan
- Aligned SW: A=0x10, rs2=0xDEADBEEF, zero-wait → cycle 1: mem_addr=4, be=1111, wdata=0xDEADBEEF, we=1; done at cycle 2, fault=0.
- Sign handling: word at 0x20 = 0x8081F0FF.
  - LB A=0x22 → rd_data=0xFFFFFF81.
  - LBU A=0x22 → 0x00000081.
  - LH A=0x20 → 0xFFFFF0FF.
  - LHU A=0x20 → 0x0000F0FF.
- Split LW A=0x43, words 0x10=0x44332211, 0x11=0x88776655:
  - req 1: addr=0x10, be=1000;
  - req 2: addr=0x11, be=0111;
  - rd_data=0x77665544, done at cycle 3.
- Split SH A=0x0B, rs2=0x0000ABCD:
  - req 1: addr=2, be=1000, wdata=0xCD000000;
  - req 2: addr=3, be=0001, wdata=0x000000AB.
- Faults, none may assert mem_req; each gives done at cycle 1 with fault=1:
  - LW at A=0x3FE (DMEM_BYTES=1024);
  - funct3=011 load;
  - is_load=is_store=1.
- Wait states and reset:
  - mem_ack delayed 3 cycles on an aligned LW → outputs held stable, done at cycle 5.
  - rst pulled low mid-ACC1 of a split access → mem_req=0 immediately, ready=1, no done.
